// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

  // Line mux select encodings.
  localparam logic [1:0] MUX_START  = 2'd0;
  localparam logic [1:0] MUX_DATA   = 2'd1;
  localparam logic [1:0] MUX_PARITY = 2'd2;
  localparam logic [1:0] MUX_STOP   = 2'd3;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Handshake, baud and serializer-side signals of the UART transmit sequencer.
interface uart_tx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IDX_W      = $clog2(DATA_WIDTH)
) ();

  logic                  baud_tick;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  data_ready;
  logic                  busy;
  logic                  ser_en;
  logic [IDX_W-1:0]      ser_data_index;
  logic [DATA_WIDTH-1:0] ser_parallel_data;
  logic                  par_bit;
  logic [1:0]            mux_sel;

  modport master (
    output baud_tick, p_data, data_valid, par_en, par_typ,
    input  data_ready, busy, ser_en, ser_data_index, ser_parallel_data, par_bit, mux_sel
  );

  modport slave (
    input  baud_tick, p_data, data_valid, par_en, par_typ,
    output data_ready, busy, ser_en, ser_data_index, ser_parallel_data, par_bit, mux_sel
  );

endinterface

// File: rtl/uart_tx_ctrl_parity_calc.sv
// Combinational parity generator; par_typ = 0 gives even parity, 1 gives odd.
module parity_calc #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par
);

  assign par = (^data) ^ par_typ;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART frame sequencer: latches a byte, then steps start/data/parity/stop on each baud_tick
// while driving the serializer load enable, bit index and line mux select.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IDX_W      = $clog2(DATA_WIDTH)
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_ctrl_if.slave  bus
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(DATA_WIDTH - 1);

  uart_tx_state_e        state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q, par_typ_q, par_bit_q;
  logic                  par_calc;

  logic                  data_ready;
  logic                  ser_en;
  logic [IDX_W-1:0]      ser_data_index;
  logic [1:0]            mux_sel;
  logic                  accept;

  parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_calc (
    .data    (bus.p_data),
    .par_typ (bus.par_typ),
    .par     (par_calc)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mux_sel        = MUX_STOP;
    ser_en         = 1'b0;
    ser_data_index = '0;
    data_ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        data_ready = 1'b1;
        if (bus.data_valid) state_d = START;
      end
      START: begin
        mux_sel = MUX_START;
        // Bit 0 is preloaded so the serializer shows it from the first DATA cycle.
        ser_en  = 1'b1;
        if (bus.baud_tick) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        mux_sel = MUX_DATA;
        if (bus.baud_tick) begin
          if (cnt_q == LastIdx) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            cnt_d          = cnt_q + 1'b1;
            ser_en         = 1'b1;
            ser_data_index = cnt_q + 1'b1;
          end
        end
      end
      PARITY: begin
        mux_sel = MUX_PARITY;
        if (bus.baud_tick) state_d = STOP;
      end
      STOP: begin
        mux_sel = MUX_STOP;
        if (bus.baud_tick) begin
          // Accepting on the stop tick chains frames with no idle gap.
          data_ready = 1'b1;
          state_d    = bus.data_valid ? START : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = bus.data_valid && data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        data_q    <= bus.p_data;
        par_en_q  <= bus.par_en;
        par_typ_q <= bus.par_typ;
        par_bit_q <= par_calc;
      end
    end
  end

  assign bus.data_ready        = data_ready;
  assign bus.busy              = (state_q != IDLE);
  assign bus.ser_en            = ser_en;
  assign bus.ser_data_index    = ser_data_index;
  assign bus.ser_parallel_data = data_q;
  assign bus.par_bit           = par_bit_q;
  assign bus.mux_sel           = mux_sel;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized and directed checks of uart_tx_ctrl against a frame-level queue model of the line.
module tb_uart_tx_ctrl;
  import uart_tx_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Serializer register and line mux that sit downstream of the controller.
  logic ser_q;
  logic line;
  always @(posedge clk or posedge reset) begin
    if (reset) ser_q <= 1'b0;
    else if (bus.ser_en) ser_q <= bus.ser_parallel_data[bus.ser_data_index];
  end
  always_comb begin
    line = 1'b1;
    case (bus.mux_sel)
      MUX_START:  line = 1'b0;
      MUX_DATA:   line = ser_q;
      MUX_PARITY: line = bus.par_bit;
      default:    line = 1'b1;
    endcase
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one entry per remaining bit period of the frame in flight (front = current bit).
  logic       exp_bit[$];
  logic [1:0] exp_sel[$];
  logic       m_par = 1'b0;
  int         n_accept = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic pt);
    m_par = logic'(($countones(d) % 2) != 0) ^ pt;
    exp_bit.push_back(1'b0);
    exp_sel.push_back(MUX_START);
    for (int i = 0; i < 8; i++) begin
      exp_bit.push_back(d[i]);
      exp_sel.push_back(MUX_DATA);
    end
    if (pe) begin
      exp_bit.push_back(m_par);
      exp_sel.push_back(MUX_PARITY);
    end
    exp_bit.push_back(1'b1);
    exp_sel.push_back(MUX_STOP);
    n_accept++;
  endtask

  // One clock: drive inputs after the falling edge, check, then advance the model.
  task automatic cyc(input logic tk, input logic dv, input logic [7:0] d,
                     input logic pe, input logic pt);
    logic exp_ready;
    @(negedge clk);
    bus.baud_tick  = tk;
    bus.data_valid = dv;
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    #1;
    exp_ready = (exp_bit.size() == 0) || (exp_bit.size() == 1 && tk);
    check_eq("busy", 32'(bus.busy), 32'(exp_bit.size() != 0));
    check_eq("data_ready", 32'(bus.data_ready), 32'(exp_ready));
    if (exp_bit.size() != 0) begin
      check_eq("mux_sel", 32'(bus.mux_sel), 32'(exp_sel[0]));
      check_eq("line", 32'(line), 32'(exp_bit[0]));
      check_eq("par_bit", 32'(bus.par_bit), 32'(m_par));
    end else begin
      check_eq("idle_mux_sel", 32'(bus.mux_sel), 32'(MUX_STOP));
      check_eq("idle_line", 32'(line), 32'd1);
    end
    if (bus.ser_en) check_eq("index_range", 32'(bus.ser_data_index <= 3'd7), 32'd1);
    if (tk && exp_bit.size() != 0) begin
      void'(exp_bit.pop_front());
      void'(exp_sel.pop_front());
    end
    if (dv && exp_ready) push_frame(d, pe, pt);
  endtask

  // Sends one frame from idle with a fixed tick period; counts busy cycles after accept.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input int period,
                      input int pulse_at, output int busy_cnt);
    int k;
    busy_cnt = 0;
    cyc(1'b0, 1'b1, d, pe, pt);
    k = 1;
    while (exp_bit.size() != 0 && k < 400) begin
      cyc(logic'((k % period) == 0), logic'(k == pulse_at),
          (k == pulse_at) ? 8'hFF : 8'($urandom), 1'b0, 1'b0);
      if (bus.busy) busy_cnt++;
      k++;
    end
    check_eq("frame_done", 32'(exp_bit.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_mux_sel"}, 32'(bus.mux_sel), 32'(MUX_STOP));
    check_eq({tag, "_ser_en"}, 32'(bus.ser_en), 32'd0);
    check_eq({tag, "_index"}, 32'(bus.ser_data_index), 32'd0);
    check_eq({tag, "_pdata"}, 32'(bus.ser_parallel_data), 32'd0);
    check_eq({tag, "_par_bit"}, 32'(bus.par_bit), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_eq({tag, "_ready"}, 32'(bus.data_ready), 32'd1);
  endtask

  initial begin
    int bc;
    int low_cnt;
    int k;
    bus.baud_tick  = 1'b0;
    bus.data_valid = 1'b0;
    bus.p_data     = '0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    #1;
    check_reset_values("por");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Plain 8N1 frame, tick every 4 clocks.
    send(8'hA5, 1'b0, 1'b0, 4, -1, bc);
    check_eq("a5_busy_cycles", 32'(bc), 32'd40);
    send(8'hA5, 1'b1, 1'b0, 4, -1, bc);
    check_eq("a5_even_par", 32'(bus.par_bit), 32'd0);
    check_eq("a5_even_len", 32'(bc), 32'd44);
    send(8'hA5, 1'b1, 1'b1, 4, -1, bc);
    check_eq("a5_odd_par", 32'(bus.par_bit), 32'd1);
    check_eq("a5_odd_len", 32'(bc), 32'd44);
    send(8'h07, 1'b1, 1'b0, 2, -1, bc);
    check_eq("07_even_par", 32'(bus.par_bit), 32'd1);
    send(8'h07, 1'b1, 1'b1, 1, -1, bc);
    check_eq("07_odd_par", 32'(bus.par_bit), 32'd0);
    check_eq("07_tick_every_clk", 32'(bc), 32'd11);

    // Back-to-back frames with data_valid held high.
    n_accept = 0;
    low_cnt  = 0;
    cyc(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0);
    k = 1;
    while (exp_bit.size() != 0 && k < 400) begin
      cyc(logic'((k % 4) == 0), logic'(n_accept < 2), 8'hC3, 1'b0, 1'b0);
      if (!bus.busy) low_cnt++;
      k++;
    end
    check_eq("b2b_accepts", 32'(n_accept), 32'd2);
    check_eq("b2b_busy_gap", 32'(low_cnt), 32'd0);

    // Reset while the fourth data bit (counter = 3) is on the line.
    cyc(1'b0, 1'b1, 8'h12, 1'b1, 1'b0);
    k = 1;
    while (exp_bit.size() != 7 && k < 100) begin
      cyc(logic'((k % 2) == 0), 1'b0, 8'h00, 1'b0, 1'b0);
      k++;
    end
    check_eq("reached_cnt3", 32'(exp_bit.size()), 32'd7);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values("mid");
    exp_bit.delete();
    exp_sel.delete();
    m_par = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    send(8'h55, 1'b0, 1'b0, 3, -1, bc);
    check_eq("post_reset_len", 32'(bc), 32'd30);

    // Valid pulse in mid-DATA must be ignored.
    n_accept = 0;
    send(8'h00, 1'b0, 1'b0, 4, 14, bc);
    check_eq("ignored_accepts", 32'(n_accept), 32'd1);
    check_eq("ignored_pdata", 32'(bus.ser_parallel_data), 32'h00);
    for (int i = 0; i < 8; i++) cyc(1'($urandom), 1'b0, 8'($urandom), 1'b0, 1'b0);

    // Random ticks, valids, data and parity settings.
    for (int i = 0; i < 4000; i++) begin
      cyc(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 9) == 0),
          8'($urandom), 1'($urandom), 1'($urandom));
    end
    k = 0;
    while (exp_bit.size() != 0 && k < 100) begin
      cyc(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
      k++;
    end
    check_eq("drain_done", 32'(exp_bit.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame sequencer for the UART transmitter.
- Accepts a parallel byte and latches it, computes parity, and drives the bit-serializer (enable and bit index).
- Selects the output bit through a 4-way line mux: start, data, parity or stop.
- Advances one bit per baud_tick, so one instance serves any baud rate generated upstream.

Parameters:
- DATA_WIDTH, 8, data bits per frame; must be ≥2.
- IDX_W, $clog2(DATA_WIDTH), width of the bit index and the data counter.

Ports:
- clk  in  1  transmitter clock.
- reset  in  1  asynchronous reset, active-high.
- baud_tick  in  1  single-cycle strobe; each strobe ends the current bit period.
- p_data  in  DATA_WIDTH  byte to send.
- data_valid  in  1  p_data is valid.
- par_en  in  1  insert a parity bit; sampled at accept.
- par_typ  in  1  0 = even, 1 = odd; sampled at accept.
- data_ready  out  1  combinational; a transfer is accepted when data_valid && data_ready.
- busy  out  1  high while a frame is in progress (state != IDLE).
- ser_en  out  1  serializer load enable.
- ser_data_index  out  IDX_W  index of the bit the serializer loads.
- ser_parallel_data  out  DATA_WIDTH  latched byte, wired to the serializer data input.
- par_bit  out  1  parity of the latched byte.
- mux_sel  out  2  line mux select.

Behaviour:
- Reset values, applied asynchronously, including mid-frame:
  - state = IDLE, mux_sel = STOP (line idles high).
  - ser_en = 0, ser_data_index = 0.
  - ser_parallel_data = 0, par_bit = 0, busy = 0, data_ready = 1.
  - Stored par_en/par_typ = 0, data counter = 0.
- The serializer registers its output: data loaded when ser_en is high is visible one cycle later. The controller therefore loads each data bit on the same edge that enters that bit's period.
- States and transitions:
  - IDLE:
    - mux_sel = STOP, data_ready = 1.
    - On accept: latch p_data, par_en, par_typ; register par_bit (XOR-reduce of p_data, inverted if par_typ = 1); go to START.
    - baud_tick is ignored in IDLE.
  - START:
    - mux_sel = START; ser_en = 1 and ser_data_index = 0 every cycle.
    - On baud_tick: go to DATA with counter = 0. The serializer holds bit 0 from the first DATA cycle.
    - A tick in the first START cycle is legal and is honoured.
  - DATA:
    - mux_sel = DATA.
    - On baud_tick with counter < DATA_WIDTH-1: counter increments; ser_en = 1 in that cycle with ser_data_index = counter+1.
    - On baud_tick with counter = DATA_WIDTH-1: go to PARITY if the stored par_en = 1, else to STOP; no ser_en.
    - ser_en = 0 whenever baud_tick is low.
  - PARITY:
    - mux_sel = PARITY.
    - On baud_tick: go to STOP.
  - STOP:
    - mux_sel = STOP.
    - On baud_tick with data_valid = 1: data_ready = 1 in that cycle; accept, latch and go directly to START (back-to-back frames, no idle gap).
    - On baud_tick with data_valid = 0: go to IDLE.
- data_ready = (state == IDLE) || (state == STOP && baud_tick).
- data_valid while busy and not ready is ignored; p_data changes do not affect the frame in flight.
- Frame length in ticks: 1 + DATA_WIDTH + par_en + 1, with the start-bit period beginning at accept.
- LSB is sent first; ser_data_index never exceeds DATA_WIDTH-1.
- busy = (state != IDLE).

Decomposition:
- Package uart_tx_pkg holds:
  - The state enum: IDLE, START, DATA, PARITY, STOP.
  - mux_sel constants: MUX_START = 2'd0, MUX_DATA = 2'd1, MUX_PARITY = 2'd2, MUX_STOP = 2'd3.
- One sub-module, parity_calc: combinational, with inputs data and par_typ and output par.
  - Its output is registered in uart_tx_ctrl at accept.
  - It is reused by the receiver's parity checker.

Test Plan:
- 0xA5, par_en = 0, tick every 4 clk → mux_sel sequence START, DATA×8, STOP; ser_data_index 0..7 with bits 1,0,1,0,0,1,0,1; busy high for 40 clk; line matches 0,1,0,1,0,0,1,0,1,1.
- 0xA5 with par_en = 1: par_typ = 0 → par_bit = 0; par_typ = 1 → par_bit = 1. In both cases the PARITY period lasts exactly one tick and the frame is 11 ticks.
- 0x07 with par_en = 1: par_typ = 0 → par_bit = 1; par_typ = 1 → par_bit = 0.
- data_valid held high with 0x3C then 0xC3 → second accept occurs on the STOP tick, START follows with no IDLE cycle, and busy never drops between the frames.
- Assert reset for 1 clk during DATA at counter = 3 → outputs go to reset values immediately; the next accept of 0x55 produces a clean full frame.
- data_valid pulsed with 0xFF during DATA of a 0x00 frame → ignored: data_ready = 0, the frame in flight is unchanged, and no second frame is sent.
